// File: rtl/dxp_cam_ctrl_v.sv
// -----------------------------------------------------------------------------
// dxp_cam_ctrl_v
// Sequencing controller for the tag CAM of the 2-way cache datapath.
//
// A lookup request is accepted on req_valid & req_ready. The tag is driven onto
// cam_argin for one compare cycle. During that cycle the entry at the
// replacement pointer is also read, so the victim is already captured if the
// lookup misses. A miss with req_alloc set writes the tag at the round-robin
// pointer and reports the evicted tag. A flush rewrites every entry with the
// all-ones invalid tag, one entry per cycle.
//
// Ports
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready        lookup request handshake
//   req_tag, req_alloc         tag to look up; allocate it on a miss
//   flush / flush_done         flush request pulse / one-cycle completion pulse
//   resp_valid/resp_ready      response handshake; resp_* held until accepted
//   resp_hit, resp_idx         hit flag and hit index (allocated index on a miss)
//   resp_victim, resp_err      evicted tag; illegal tag or multi-hit
//   cam_we, cam_rd             CAM write / read enables (never both)
//   cam_din, cam_argin         CAM write data / match argument
//   cam_addrs                  CAM address
//   cam_dout, cam_mbits        CAM read data / match bits
//
// Optional feature (macro DXP_CAM_CTRL_STATS_EN)
//   Adds hit_cnt[15:0] and miss_cnt[15:0]: saturating counts of accepted
//   responses without resp_err, cleared by rst and by flush completion.
// -----------------------------------------------------------------------------
module dxp_cam_ctrl_v #(
  parameter int TAG_W = 3,
  parameter int BL    = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             req_alloc,
  input  logic             flush,
  output logic             flush_done,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_hit,
  output logic [AW-1:0]    resp_idx,
  output logic [TAG_W-1:0] resp_victim,
  output logic             resp_err,
  output logic             cam_we,
  output logic             cam_rd,
  output logic [TAG_W-1:0] cam_din,
  output logic [TAG_W-1:0] cam_argin,
  output logic [AW-1:0]    cam_addrs,
  input  logic [TAG_W-1:0] cam_dout,
  input  logic [BL-1:0]    cam_mbits
`ifdef DXP_CAM_CTRL_STATS_EN
  ,
  output logic [15:0]      hit_cnt,
  output logic [15:0]      miss_cnt
`endif
);

  localparam logic [AW-1:0]    LAST_IDX = AW'(BL - 1);
  localparam logic [TAG_W-1:0] INV_TAG  = {TAG_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMP,
    S_ALLOC,
    S_RESP,
    S_FLUSH
  } state_t;

  // Index of the lowest set match bit.
  function automatic logic [AW-1:0] low_idx(input logic [BL-1:0] m);
    logic [AW-1:0] r;
    r = '0;
    for (int i = BL - 1; i >= 0; i--) begin
      if (m[i]) r = AW'(i);
    end
    return r;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic multi_hit(input logic [BL-1:0] m);
    return (m & (m - BL'(1))) != '0;
  endfunction

`ifdef DXP_CAM_CTRL_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction
`endif

  // Control and output registers (reset)
  state_t           state_q,       state_d;
  logic             req_ready_q,   req_ready_d;
  logic             flush_done_q,  flush_done_d;
  logic             resp_valid_q,  resp_valid_d;
  logic             resp_hit_q,    resp_hit_d;
  logic [AW-1:0]    resp_idx_q,    resp_idx_d;
  logic [TAG_W-1:0] resp_victim_q, resp_victim_d;
  logic             resp_err_q,    resp_err_d;
  logic             cam_we_q,      cam_we_d;
  logic             cam_rd_q,      cam_rd_d;
  logic [TAG_W-1:0] cam_din_q,     cam_din_d;
  logic [TAG_W-1:0] cam_argin_q,   cam_argin_d;
  logic [AW-1:0]    cam_addrs_q,   cam_addrs_d;
  logic [AW-1:0]    rptr_q,        rptr_d;
  logic [AW-1:0]    fcnt_q,        fcnt_d;
  logic             flush_pend_q,  flush_pend_d;
`ifdef DXP_CAM_CTRL_STATS_EN
  logic [15:0]      hit_cnt_q,     hit_cnt_d;
  logic [15:0]      miss_cnt_q,    miss_cnt_d;
`endif

  // Datapath holding registers (no reset needed: always loaded before use)
  logic [TAG_W-1:0] tag_q,    tag_d;
  logic             alloc_q,  alloc_d;
  logic [TAG_W-1:0] victim_q, victim_d;

  always_comb begin
    state_d       = state_q;
    req_ready_d   = 1'b0;
    flush_done_d  = 1'b0;
    resp_valid_d  = resp_valid_q;
    resp_hit_d    = resp_hit_q;
    resp_idx_d    = resp_idx_q;
    resp_victim_d = resp_victim_q;
    resp_err_d    = resp_err_q;
    cam_we_d      = 1'b0;
    cam_rd_d      = 1'b0;
    cam_din_d     = cam_din_q;
    cam_argin_d   = cam_argin_q;
    cam_addrs_d   = cam_addrs_q;
    rptr_d        = rptr_q;
    fcnt_d        = fcnt_q;
    flush_pend_d  = flush_pend_q;
    tag_d         = tag_q;
    alloc_d       = alloc_q;
    victim_d      = victim_q;
`ifdef DXP_CAM_CTRL_STATS_EN
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // A visible req_ready is a promise: an accepted request is honoured and
        // a coincident flush pulse is remembered. req_ready is already low
        // whenever a flush was pending on entry.
        if (req_valid && req_ready_q) begin
          tag_d        = req_tag;
          alloc_d      = req_alloc;
          cam_argin_d  = req_tag;
          cam_rd_d     = 1'b1;
          cam_addrs_d  = rptr_q;
          flush_pend_d = flush_pend_q | flush;
          state_d      = S_CMP;
        end else if (flush_pend_q || flush) begin
          flush_pend_d = 1'b0;
          fcnt_d       = '0;
          cam_we_d     = 1'b1;
          cam_addrs_d  = '0;
          cam_din_d    = INV_TAG;
          state_d      = S_FLUSH;
        end else begin
          req_ready_d  = 1'b1;
        end
      end

      S_CMP: begin
        flush_pend_d  = flush_pend_q | flush;
        victim_d      = cam_dout;
        resp_victim_d = '0;
        resp_idx_d    = '0;
        resp_hit_d    = 1'b0;
        resp_err_d    = 1'b0;
        if (tag_q == INV_TAG) begin
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (cam_mbits != '0) begin
          resp_hit_d   = 1'b1;
          resp_idx_d   = low_idx(cam_mbits);
          resp_err_d   = multi_hit(cam_mbits);
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (alloc_q) begin
          cam_we_d     = 1'b1;
          cam_addrs_d  = rptr_q;
          cam_din_d    = tag_q;
          state_d      = S_ALLOC;
        end else begin
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end
      end

      S_ALLOC: begin
        flush_pend_d  = flush_pend_q | flush;
        resp_idx_d    = rptr_q;
        resp_victim_d = victim_q;
        resp_valid_d  = 1'b1;
        rptr_d        = (rptr_q == LAST_IDX) ? '0 : rptr_q + AW'(1);
        state_d       = S_RESP;
      end

      S_RESP: begin
        flush_pend_d = flush_pend_q | flush;
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = ~(flush_pend_q | flush);
          state_d      = S_IDLE;
`ifdef DXP_CAM_CTRL_STATS_EN
          if (!resp_err_q) begin
            if (resp_hit_q) hit_cnt_d  = sat_inc(hit_cnt_q);
            else            miss_cnt_d = sat_inc(miss_cnt_q);
          end
`endif
        end
      end

      S_FLUSH: begin
        // Flush pulses seen here are absorbed by the flush already running.
        if (fcnt_q == LAST_IDX) begin
          flush_done_d = 1'b1;
          rptr_d       = '0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
`ifdef DXP_CAM_CTRL_STATS_EN
          hit_cnt_d    = '0;
          miss_cnt_d   = '0;
`endif
        end else begin
          fcnt_d       = fcnt_q + AW'(1);
          cam_we_d     = 1'b1;
          cam_addrs_d  = fcnt_q + AW'(1);
          cam_din_d    = INV_TAG;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b0;
      flush_done_q  <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_idx_q    <= '0;
      resp_victim_q <= '0;
      resp_err_q    <= 1'b0;
      cam_we_q      <= 1'b0;
      cam_rd_q      <= 1'b0;
      cam_din_q     <= '0;
      cam_argin_q   <= INV_TAG;
      cam_addrs_q   <= '0;
      rptr_q        <= '0;
      fcnt_q        <= '0;
      flush_pend_q  <= 1'b0;
`ifdef DXP_CAM_CTRL_STATS_EN
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      flush_done_q  <= flush_done_d;
      resp_valid_q  <= resp_valid_d;
      resp_hit_q    <= resp_hit_d;
      resp_idx_q    <= resp_idx_d;
      resp_victim_q <= resp_victim_d;
      resp_err_q    <= resp_err_d;
      cam_we_q      <= cam_we_d;
      cam_rd_q      <= cam_rd_d;
      cam_din_q     <= cam_din_d;
      cam_argin_q   <= cam_argin_d;
      cam_addrs_q   <= cam_addrs_d;
      rptr_q        <= rptr_d;
      fcnt_q        <= fcnt_d;
      flush_pend_q  <= flush_pend_d;
`ifdef DXP_CAM_CTRL_STATS_EN
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    alloc_q  <= alloc_d;
    victim_q <= victim_d;
  end

  assign req_ready   = req_ready_q;
  assign flush_done  = flush_done_q;
  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_hit_q;
  assign resp_idx    = resp_idx_q;
  assign resp_victim = resp_victim_q;
  assign resp_err    = resp_err_q;
  assign cam_we      = cam_we_q;
  assign cam_rd      = cam_rd_q;
  assign cam_din     = cam_din_q;
  assign cam_argin   = cam_argin_q;
  assign cam_addrs   = cam_addrs_q;
`ifdef DXP_CAM_CTRL_STATS_EN
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dxp_cam_ctrl_v.sv
// -----------------------------------------------------------------------------
// tb_dxp_cam_ctrl_v
// Bench for dxp_cam_ctrl_v: a 16x3 CAM behavioural model sits on the CAM port;
// a transaction-level reference (expected contents, replacement pointer)
// predicts every response. Directed scenarios pin the model, then a random
// phase mixes lookups, allocations and flushes.
// -----------------------------------------------------------------------------
module tb_dxp_cam_ctrl_v;
  localparam int TAG_W = 3;
  localparam int BL    = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_alloc;
  logic [TAG_W-1:0] req_tag;
  logic             flush, flush_done;
  logic             resp_valid, resp_ready, resp_hit, resp_err;
  logic [AW-1:0]    resp_idx;
  logic [TAG_W-1:0] resp_victim;
  logic             cam_we, cam_rd;
  logic [TAG_W-1:0] cam_din, cam_argin, cam_dout;
  logic [AW-1:0]    cam_addrs;
  logic [BL-1:0]    cam_mbits;
`ifdef DXP_CAM_CTRL_STATS_EN
  logic [15:0]      hit_cnt, miss_cnt;
  int               ref_hits = 0, ref_miss = 0;
`endif

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int excl_viol = 0;

  // CAM model plus an override of the match bits for forced scenarios
  logic [TAG_W-1:0] cam_mem [BL];
  logic             force_en = 1'b0;
  logic [BL-1:0]    force_val = '0;

  // Reference model of CAM contents and the replacement pointer
  logic [TAG_W-1:0] ref_mem [BL];
  int               ref_rptr = 0;

  always #5 clk = ~clk;

  dxp_cam_ctrl_v #(.TAG_W(TAG_W), .BL(BL), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .req_alloc(req_alloc),
    .flush(flush), .flush_done(flush_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_idx(resp_idx), .resp_victim(resp_victim), .resp_err(resp_err),
    .cam_we(cam_we), .cam_rd(cam_rd), .cam_din(cam_din), .cam_argin(cam_argin),
    .cam_addrs(cam_addrs), .cam_dout(cam_dout), .cam_mbits(cam_mbits)
`ifdef DXP_CAM_CTRL_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always @(posedge clk) if (cam_we) cam_mem[cam_addrs] <= cam_din;

  always_comb begin
    cam_dout  = cam_mem[cam_addrs];
    cam_mbits = '0;
    for (int i = 0; i < BL; i++) cam_mbits[i] = (cam_mem[i] == cam_argin);
    if (force_en) cam_mbits = force_val;
  end

  // Every-cycle observation of the CAM strobes
  always @(negedge clk) begin
    if (cam_we) we_cnt++;
    if (cam_we && cam_rd) excl_viol++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic stats_clear();
`ifdef DXP_CAM_CTRL_STATS_EN
    ref_hits = 0;
    ref_miss = 0;
`endif
  endtask

  // Called at the negedge of the first flush write cycle.
  task automatic check_flush_writes();
    for (int i = 0; i < BL; i++) begin
      chk("flush_we", cam_we, 1);
      chk("flush_addr", cam_addrs, i);
      chk("flush_din", cam_din, 3'b111);
      chk("flush_done_early", flush_done, 0);
      @(negedge clk);
    end
    chk("flush_done", flush_done, 1);
    chk("flush_we_end", cam_we, 0);
    chk("flush_ready_end", req_ready, 1);
    for (int i = 0; i < BL; i++) ref_mem[i] = 3'b111;
    ref_rptr = 0;
    stats_clear();
  endtask

  task automatic do_flush();
    int n;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    while (!cam_we && n < 40) begin @(negedge clk); n++; end
    chk("flush_start", cam_we, 1);
    check_flush_writes();
  endtask

  task automatic check_mem();
    for (int i = 0; i < BL; i++) chk("cam_contents", cam_mem[i], ref_mem[i]);
  endtask

  task automatic lookup(input logic [2:0] tag, input bit alloc, input int rdly, input bit flush_in_resp,
                        output logic o_hit, output logic [3:0] o_idx,
                        output logic [2:0] o_vic, output logic o_err);
    logic [BL-1:0] m;
    bit            e_hit, e_err;
    logic [3:0]    e_idx;
    logic [2:0]    e_vic;
    int            lat, e_we, w0, n, ones;
    if (force_en) m = force_val;
    else for (int i = 0; i < BL; i++) m[i] = (ref_mem[i] == tag);
    ones  = $countones(m);
    e_hit = 0; e_err = 0; e_idx = 0; e_vic = 0; lat = 2; e_we = 0;
    if (tag == 3'b111) begin
      e_err = 1;
    end else if (ones > 0) begin
      e_hit = 1;
      e_err = (ones > 1);
      for (int i = 0; i < BL; i++) if (m[i]) begin e_idx = 4'(i); break; end
    end else if (alloc) begin
      e_idx = 4'(ref_rptr);
      e_vic = ref_mem[ref_rptr];
      lat   = 3;
      e_we  = 1;
    end

    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready", req_ready, 1);
    w0        = we_cnt;
    req_valid = 1'b1;
    req_tag   = tag;
    req_alloc = alloc;
    @(negedge clk);
    req_valid = 1'b0;
    req_alloc = 1'b0;
    req_tag   = 3'($urandom);
    for (int j = 1; j < lat; j++) begin
      chk("resp_early", resp_valid, 0);
      @(negedge clk);
    end
    chk("resp_valid", resp_valid, 1);
    o_hit = resp_hit; o_idx = resp_idx; o_vic = resp_victim; o_err = resp_err;
    for (int k = 0; k <= rdly; k++) begin
      chk("resp_valid_hold", resp_valid, 1);
      chk("resp_hit", resp_hit, e_hit);
      chk("resp_idx", resp_idx, e_idx);
      chk("resp_err", resp_err, e_err);
      if (!e_hit) chk("resp_victim", resp_victim, e_vic);
      if (flush_in_resp) flush = (k == 0);
      if (k == rdly) resp_ready = 1'b1;
      @(negedge clk);
    end
    flush      = 1'b0;
    resp_ready = 1'b0;
    chk("resp_drop", resp_valid, 0);
    chk("req_ready_after", req_ready, !flush_in_resp);
    chk("cam_we_count", we_cnt - w0, e_we);
    if (e_we != 0) begin
      ref_mem[ref_rptr] = tag;
      ref_rptr = (ref_rptr + 1) % BL;
    end
`ifdef DXP_CAM_CTRL_STATS_EN
    if (!e_err) begin
      if (e_hit) ref_hits = (ref_hits < 65535) ? ref_hits + 1 : ref_hits;
      else       ref_miss = (ref_miss < 65535) ? ref_miss + 1 : ref_miss;
    end
    chk("hit_cnt", hit_cnt, ref_hits);
    chk("miss_cnt", miss_cnt, ref_miss);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       h, e;
    logic [3:0] ix;
    logic [2:0] v;
    int         w0;
    rst = 1'b0; req_valid = 1'b0; req_tag = '0; req_alloc = 1'b0;
    flush = 1'b0; resp_ready = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_cam_we", cam_we, 0);
    chk("rst_cam_rd", cam_rd, 0);
    chk("rst_cam_argin", cam_argin, 3'b111);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_resp_idx", resp_idx, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", req_ready, 1);

    // Flush after reset, then allocate and re-find tag 2
    do_flush();
    lookup(3'b010, 1, 0, 0, h, ix, v, e);
    chk("first_alloc_hit", h, 0);
    chk("first_alloc_idx", ix, 0);
    chk("first_alloc_victim", v, 3'b111);
    lookup(3'b010, 1, 1, 0, h, ix, v, e);
    chk("relookup_hit", h, 1);
    chk("relookup_idx", ix, 0);

    // Two forced matches at entries 2 and 4
    force_en = 1'b1; force_val = 16'h0014;
    lookup(3'b101, 0, 0, 0, h, ix, v, e);
    chk("multi_hit", h, 1);
    chk("multi_idx", ix, 2);
    chk("multi_err", e, 1);
    force_en = 1'b0;

    // Invalid tag
    lookup(3'b111, 1, 0, 0, h, ix, v, e);
    chk("inv_err", e, 1);
    chk("inv_hit", h, 0);

    // 17 forced misses: pointer wraps and evicts the first tag
    do_flush();
    force_en = 1'b1; force_val = '0;
    for (int i = 0; i < 17; i++) begin
      lookup(3'(i % 7), 1, 0, 0, h, ix, v, e);
      if (i == 15) chk("wrap_idx15", ix, 15);
      if (i == 16) begin
        chk("wrap_idx", ix, 0);
        chk("wrap_victim", v, 3'b000);
      end
    end
    force_en = 1'b0;
    check_mem();

    // Flush pulse while a response is held: runs after IDLE is re-entered
    do_flush();
    lookup(3'b011, 1, 3, 1, h, ix, v, e);
    chk("pend_idle_we", cam_we, 0);
    @(negedge clk);
    check_flush_writes();

    // Reset in the middle of a flush
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (4) @(negedge clk);
    chk("midflush_we", cam_we, 1);
    rst = 1'b1;
    #1;
    w0 = we_cnt;
    chk("rstflush_we", cam_we, 0);
    chk("rstflush_ready", req_ready, 0);
    chk("rstflush_argin", cam_argin, 3'b111);
    @(negedge clk);
    rst = 1'b0;
    ref_rptr = 0;
    stats_clear();
    @(negedge clk);
    chk("rstflush_idle_ready", req_ready, 1);
    chk("rstflush_no_writes", we_cnt - w0, 0);
    chk("rstflush_no_done", flush_done, 0);
    do_flush();

    // Random traffic
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 11) == 0) do_flush();
      else lookup(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), 0, h, ix, v, e);
    end
    check_mem();

    chk("we_rd_exclusive", excl_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
